// File: rtl/tinynpu_seq_pkg.sv
// tinynpu_seq_pkg: shared definitions for the TinyNPU layer sequencer.
//   NPU_LD0/MAC/LD1/OUT : encodings of the NPU trace_state input.
//   seq_state_t         : sequencer FSM states.
//   words_per_layer()   : weight words per layer (SIZE*SIZE).
package tinynpu_seq_pkg;

  localparam logic [1:0] NPU_LD0 = 2'd0;
  localparam logic [1:0] NPU_MAC = 2'd1;
  localparam logic [1:0] NPU_LD1 = 2'd2;
  localparam logic [1:0] NPU_OUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    LDX,
    LDW,
    DRAIN,
    GO,
    WAIT,
    FIN
  } seq_state_t;

  localparam int unsigned SEQ_SIZE_DEFAULT = 4;

  function automatic int unsigned words_per_layer(input int unsigned size);
    return size * size;
  endfunction

endpackage

// File: rtl/tinynpu_layer_seq_if.sv
// tinynpu_layer_seq_if: host command port of the layer sequencer.
//   cmd_val/cmd_rdy : descriptor handshake
//   cmd_x_base      : address of x word 0
//   cmd_w_base      : address of layer-0 weight word 0
//   cmd_nlayers     : layer count 0..15
// master = host side, slave = sequencer side.
interface tinynpu_layer_seq_if #(
  parameter int ADDR_W = 16
);
  logic              cmd_val;
  logic              cmd_rdy;
  logic [ADDR_W-1:0] cmd_x_base;
  logic [ADDR_W-1:0] cmd_w_base;
  logic [3:0]        cmd_nlayers;

  modport master (
    output cmd_val, cmd_x_base, cmd_w_base, cmd_nlayers,
    input  cmd_rdy
  );

  modport slave (
    input  cmd_val, cmd_x_base, cmd_w_base, cmd_nlayers,
    output cmd_rdy
  );
endinterface

// File: rtl/tinynpu_seq_addr_gen.sv
// tinynpu_seq_addr_gen: burst word counter for the layer sequencer.
//   clk, rst    : clock, async active-high reset
//   start       : clear the word counter (wins over step)
//   step        : advance the word counter by one
//   short_burst : 1 = SIZE-word burst (x vector), 0 = SIZE*SIZE-word burst (weights)
//   base        : burst base address
//   addr        : base + word index, wrapping modulo 2^ADDR_W
//   row         : word index / SIZE (weight-FIFO row)
//   last        : current word is the final word of the burst
module tinynpu_seq_addr_gen
  import tinynpu_seq_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      step,
  input  logic                      short_burst,
  input  logic [ADDR_W-1:0]         base,
  output logic [ADDR_W-1:0]         addr,
  output logic [$clog2(SIZE)-1:0]   row,
  output logic                      last
);
  localparam int unsigned WPL   = words_per_layer(SIZE);
  localparam int          CNT_W = $clog2(WPL);
  localparam int          ROW_W = $clog2(SIZE);

  logic [CNT_W-1:0] k;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k <= '0;
    end else if (start) begin
      k <= '0;
    end else if (step) begin
      k <= k + CNT_W'(1);
    end
  end

  always_comb begin
    addr = base + ADDR_W'(k);
    row  = ROW_W'(k / CNT_W'(SIZE));
    last = short_burst ? (k == CNT_W'(SIZE - 1)) : (k == CNT_W'(WPL - 1));
  end

endmodule

// File: rtl/tinynpu_layer_seq.sv
// tinynpu_layer_seq: layer sequencer between the host command port and the
// TinyNPU controller. Fetches the x vector and per-layer weights from a
// 1-cycle-latency memory, drives the NPU load strobes, then issues mac_val
// per layer and out_val after the last layer, tracking the NPU trace state.
//   clk, rst        : clock, async active-high reset (shared with the NPU)
//   cmd             : descriptor port (tinynpu_layer_seq_if.slave)
//   mem_ren/addr    : memory read request
//   npu_x_load_val, npu_w_load_val, npu_w_load_sel : NPU load strobes,
//                     request delayed one cycle to align with memory data
//   npu_mac_val, npu_out_val : NPU phase requests
//   npu_state       : NPU trace_state (LD0/MAC/LD1/OUT)
//   busy, done      : sequencer status, done is a one-cycle pulse
// Optional macro TINYNPU_SEQ_PERF_EN adds perf_cycles[31:0], a saturating
// busy-cycle counter cleared on command accept.
module tinynpu_layer_seq
  import tinynpu_seq_pkg::*;
#(
  parameter int SIZE   = 4,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  tinynpu_layer_seq_if.slave      cmd,
  output logic                    mem_ren,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    npu_x_load_val,
  output logic                    npu_w_load_val,
  output logic [$clog2(SIZE)-1:0] npu_w_load_sel,
  output logic                    npu_mac_val,
  output logic                    npu_out_val,
  input  logic [1:0]              npu_state,
  output logic                    busy,
  output logic                    done
`ifdef TINYNPU_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_cycles
`endif
);
  localparam int unsigned WPL   = words_per_layer(SIZE);
  localparam int          ROW_W = $clog2(SIZE);

  seq_state_t state, state_nx;

  logic [ADDR_W-1:0] x_base, w_base;
  logic [3:0]        nlayers, layer_cnt;
  logic              zero_pending;
  logic              accept, more_layers, loading, mac_taken;

  logic [ADDR_W-1:0] gen_base, gen_addr;
  logic [ROW_W-1:0]  gen_row;
  logic              gen_last;

  // Request-side registers; the load strobes are these delayed one cycle.
  logic              req_is_x;
  logic [ROW_W-1:0]  req_row;

  logic              ren_d, is_x_d, mac_d, out_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ROW_W-1:0]  row_d;

  assign cmd.cmd_rdy = (state == IDLE) && (npu_state == NPU_LD0);
  assign accept      = cmd.cmd_val && cmd.cmd_rdy;
  assign busy        = (state != IDLE);
  assign more_layers = (layer_cnt < nlayers);
  assign loading     = (state == LDX) || (state == LDW);
  assign mac_taken   = (state == GO) && more_layers && (npu_state == NPU_MAC);
  assign gen_base    = (state == LDX) ? x_base
                                      : w_base + ADDR_W'(layer_cnt * WPL);

  tinynpu_seq_addr_gen #(
    .SIZE   (SIZE),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .start       (!loading || gen_last),
    .step        (loading),
    .short_burst (state == LDX),
    .base        (gen_base),
    .addr        (gen_addr),
    .row         (gen_row),
    .last        (gen_last)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (accept && (cmd.cmd_nlayers != '0)) state_nx = LDX;
      LDX:   if (gen_last) state_nx = LDW;
      LDW:   if (gen_last) state_nx = DRAIN;
      DRAIN: state_nx = GO;
      GO: begin
        if (more_layers) begin
          if (npu_state == NPU_MAC) state_nx = WAIT;
        end else if (npu_state == NPU_OUT) begin
          state_nx = FIN;
        end
      end
      WAIT:  if (npu_state == NPU_LD1) state_nx = more_layers ? LDW : GO;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs. The phase requests
  // drop in the same cycle the NPU acknowledgement is sampled.
  always_comb begin
    ren_d  = loading;
    addr_d = loading ? gen_addr : '0;
    is_x_d = (state == LDX);
    row_d  = (state == LDW) ? gen_row : '0;
    mac_d  = (state == GO) && more_layers && (npu_state != NPU_MAC);
    out_d  = (state == GO) && !more_layers && (npu_state != NPU_OUT);
    done_d = (state == FIN) || zero_pending;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ren        <= 1'b0;
      mem_addr       <= '0;
      req_is_x       <= 1'b0;
      req_row        <= '0;
      npu_x_load_val <= 1'b0;
      npu_w_load_val <= 1'b0;
      npu_w_load_sel <= '0;
      npu_mac_val    <= 1'b0;
      npu_out_val    <= 1'b0;
      done           <= 1'b0;
    end else begin
      mem_ren        <= ren_d;
      mem_addr       <= addr_d;
      req_is_x       <= is_x_d;
      req_row        <= row_d;
      npu_x_load_val <= mem_ren && req_is_x;
      npu_w_load_val <= mem_ren && !req_is_x;
      npu_w_load_sel <= req_row;
      npu_mac_val    <= mac_d;
      npu_out_val    <= out_d;
      done           <= done_d;
    end
  end

  // Descriptor and layer bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_base       <= '0;
      w_base       <= '0;
      nlayers      <= '0;
      layer_cnt    <= '0;
      zero_pending <= 1'b0;
    end else begin
      zero_pending <= 1'b0;
      if (accept) begin
        x_base       <= cmd.cmd_x_base;
        w_base       <= cmd.cmd_w_base;
        nlayers      <= cmd.cmd_nlayers;
        layer_cnt    <= '0;
        zero_pending <= (cmd.cmd_nlayers == '0);
      end else if (mac_taken) begin
        layer_cnt    <= layer_cnt + 4'd1;
      end
    end
  end

`ifdef TINYNPU_SEQ_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tinynpu_layer_seq.sv
// tb_tinynpu_layer_seq: directed bench for tinynpu_layer_seq with a small
// behavioural NPU (LD0 -> MAC -> LD1 -> MAC/OUT) whose LD1 ostream-ready
// delay is programmable. Cycle numbers are relative to the accept edge.
module tb_tinynpu_layer_seq;
  import tinynpu_seq_pkg::*;

  localparam int SIZE   = 4;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tinynpu_layer_seq_if #(.ADDR_W(ADDR_W)) cmd_if ();

  logic              mem_ren;
  logic [ADDR_W-1:0] mem_addr;
  logic              npu_x_load_val, npu_w_load_val;
  logic [1:0]        npu_w_load_sel;
  logic              npu_mac_val, npu_out_val;
  logic [1:0]        npu_state;
  logic              busy, done;
`ifdef TINYNPU_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  tinynpu_layer_seq #(.SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd            (cmd_if),
    .mem_ren        (mem_ren),
    .mem_addr       (mem_addr),
    .npu_x_load_val (npu_x_load_val),
    .npu_w_load_val (npu_w_load_val),
    .npu_w_load_sel (npu_w_load_sel),
    .npu_mac_val    (npu_mac_val),
    .npu_out_val    (npu_out_val),
    .npu_state      (npu_state),
    .busy           (busy),
    .done           (done)
`ifdef TINYNPU_SEQ_PERF_EN
    ,
    .perf_cycles    (perf_cycles)
`endif
  );

  // ---------------- NPU model ----------------
  // MAC lasts 3 cycles; in LD1 a pending request is held off ld1_delay cycles.
  int unsigned ld1_delay = 0;
  int unsigned mac_cnt, rdy_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      npu_state <= NPU_LD0;
      mac_cnt   <= 0;
      rdy_cnt   <= 0;
    end else begin
      case (npu_state)
        NPU_LD0: if (npu_mac_val) begin npu_state <= NPU_MAC; mac_cnt <= 0; end
        NPU_MAC: begin
          if (mac_cnt == 2) begin npu_state <= NPU_LD1; rdy_cnt <= 0; end
          else mac_cnt <= mac_cnt + 1;
        end
        NPU_LD1: begin
          if (npu_mac_val || npu_out_val) begin
            if (rdy_cnt < ld1_delay) rdy_cnt <= rdy_cnt + 1;
            else if (npu_mac_val) begin npu_state <= NPU_MAC; mac_cnt <= 0; end
            else npu_state <= NPU_OUT;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- monitor ----------------
  int edges = 0;
  int acc_edge = 1 << 30;
  always @(posedge clk) edges <= edges + 1;

  logic [15:0] addr_q[$];
  logic [1:0]  sel_q[$];
  int          mac_len_q[$];
  int x_loads, mac_rises, out_rises, overlap, done_cnt, done_rel;
  int first_ren, first_xl, first_mac, mac_run, out_run, out_len;
  int ld1_before_out, mac_at_out;
  logic mac_prev, out_prev;
  logic [1:0] npu_prev;

  initial begin
    int rel;
    forever begin
      @(negedge clk);
      rel = edges - acc_edge;
      if (rel == 0) begin
        addr_q.delete(); sel_q.delete(); mac_len_q.delete();
        x_loads = 0; mac_rises = 0; out_rises = 0; overlap = 0;
        done_cnt = 0; done_rel = -1; first_ren = -1; first_xl = -1;
        first_mac = -1; mac_run = 0; out_run = 0; out_len = 0;
        ld1_before_out = 0; mac_at_out = -1;
      end else if (rel > 0) begin
        if (mem_ren) begin
          addr_q.push_back(mem_addr);
          if (first_ren < 0) first_ren = rel;
        end
        if (npu_x_load_val) begin
          x_loads++;
          if (first_xl < 0) first_xl = rel;
        end
        if (npu_w_load_val) sel_q.push_back(npu_w_load_sel);
        if (npu_mac_val) begin
          if (!mac_prev) begin
            mac_rises++;
            if (first_mac < 0) first_mac = rel;
          end
          mac_run++;
        end else if (mac_prev) begin
          mac_len_q.push_back(mac_run);
          mac_run = 0;
        end
        if (npu_out_val) begin
          if (!out_prev) begin
            if (out_rises == 0) mac_at_out = mac_rises;
            out_rises++;
          end
          out_run++;
        end else if (out_prev) begin
          out_len = out_run;
          out_run = 0;
        end
        if (npu_mac_val && npu_out_val) overlap++;
        if (done) begin done_cnt++; done_rel = rel; end
        if (npu_state == NPU_LD1 && npu_prev != NPU_LD1 && out_rises == 0)
          ld1_before_out++;
      end
      mac_prev = npu_mac_val;
      out_prev = npu_out_val;
      npu_prev = npu_state;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [15:0] xb, input logic [15:0] wb,
                          input logic [3:0] nl);
    int unsigned t = 0;
    @(negedge clk);
    while (!cmd_if.cmd_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_val("cmd_rdy_before_send", 32'(cmd_if.cmd_rdy), 1);
    cmd_if.cmd_x_base  = xb;
    cmd_if.cmd_w_base  = wb;
    cmd_if.cmd_nlayers = nl;
    cmd_if.cmd_val     = 1'b1;
    acc_edge = edges + 1;
    @(posedge clk);
    #1 cmd_if.cmd_val = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned t = 0;
    while (done_cnt == 0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    #1;
  endtask

  // Address stream: x_base+k for the x vector, then w_base+offset contiguous
  // across layers (layer l word k at w_base + l*16 + k).
  task automatic check_stream(input string tag, input logic [15:0] xb,
                              input logic [15:0] wb, input int nl);
    int n_exp;
    int bad_a = 0;
    int bad_s = 0;
    logic [15:0] e;
    n_exp = (nl == 0) ? 0 : SIZE + nl * SIZE * SIZE;
    check_val({tag, "_addr_cnt"}, 32'(addr_q.size()), 32'(n_exp));
    for (int i = 0; i < addr_q.size() && i < n_exp; i++) begin
      e = (i < SIZE) ? xb + 16'(i) : wb + 16'(i - SIZE);
      if (addr_q[i] !== e) bad_a++;
    end
    check_val({tag, "_addr_mismatches"}, 32'(bad_a), 0);
    check_val({tag, "_wload_cnt"}, 32'(sel_q.size()), 32'(nl * SIZE * SIZE));
    for (int i = 0; i < sel_q.size(); i++) begin
      if (sel_q[i] !== 2'((i % 16) / 4)) bad_s++;
    end
    check_val({tag, "_sel_mismatches"}, 32'(bad_s), 0);
    check_val({tag, "_xload_cnt"}, 32'(x_loads), (nl == 0) ? 0 : 4);
    check_val({tag, "_mac_phases"}, 32'(mac_rises), 32'(nl));
    check_val({tag, "_out_phases"}, 32'(out_rises), (nl == 0) ? 0 : 1);
    check_val({tag, "_mac_out_overlap"}, 32'(overlap), 0);
    check_val({tag, "_done_cnt"}, 32'(done_cnt), 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_if.cmd_val     = 1'b0;
    cmd_if.cmd_x_base  = '0;
    cmd_if.cmd_w_base  = '0;
    cmd_if.cmd_nlayers = '0;
    repeat (3) @(negedge clk);
    check_val("reset_outputs",
              32'({mem_ren, mem_addr, npu_x_load_val, npu_w_load_val,
                   npu_w_load_sel, npu_mac_val, npu_out_val, done, busy}), 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check_val("idle_cmd_rdy", 32'(cmd_if.cmd_rdy), 1);
    check_val("idle_busy", 32'(busy), 0);

    // Single layer: timing landmarks and full address/select streams
    send_cmd(16'h0010, 16'h0100, 4'd1);
    wait_done(200);
    check_stream("t1", 16'h0010, 16'h0100, 1);
    check_val("t1_first_mem_ren_cycle", 32'(first_ren), 1);
    check_val("t1_first_xload_cycle", 32'(first_xl), 2);
    check_val("t1_first_mac_cycle", 32'(first_mac), 22);
    check_val("t1_done_cycle", 32'(done_rel), 31);
    check_val("t1_mac_len", (mac_len_q.size() > 0) ? 32'(mac_len_q[0]) : 32'hFFFF_FFFF, 2);
    check_val("t1_out_len", 32'(out_len), 2);
    check_val("t1_busy_after", 32'(busy), 0);
    check_val("t1_cmd_rdy_npu_out", 32'(cmd_if.cmd_rdy), 0);
    do_reset();

    // Three layers: weight bursts at 0x100/0x110/0x120, out after third LD1
    send_cmd(16'h0010, 16'h0100, 4'd3);
    wait_done(400);
    check_stream("t2", 16'h0010, 16'h0100, 3);
    check_val("t2_ld1_before_out", 32'(ld1_before_out), 3);
    check_val("t2_macs_before_out", 32'(mac_at_out), 3);
    do_reset();

    // Zero layers: done one cycle after accept, no memory traffic
    send_cmd(16'h0050, 16'h0500, 4'd0);
    wait_done(20);
    check_stream("t3", 16'h0050, 16'h0500, 0);
    check_val("t3_done_cycle", 32'(done_rel), 1);
    check_val("t3_mem_ren_seen", 32'(first_ren), 32'hFFFF_FFFF);
    check_val("t3_busy_after", 32'(busy), 0);
    check_val("t3_cmd_rdy_after", 32'(cmd_if.cmd_rdy), 1);

    // LD1 ostream-ready delayed 7 cycles: requests held 7+2 cycles
    ld1_delay = 7;
    send_cmd(16'h0040, 16'h0200, 4'd2);
    wait_done(400);
    check_stream("t4", 16'h0040, 16'h0200, 2);
    check_val("t4_mac_len_cnt", 32'(mac_len_q.size()), 2);
    check_val("t4_mac_len0", (mac_len_q.size() > 0) ? 32'(mac_len_q[0]) : 32'hFFFF_FFFF, 2);
    check_val("t4_mac_len1", (mac_len_q.size() > 1) ? 32'(mac_len_q[1]) : 32'hFFFF_FFFF, 9);
    check_val("t4_out_len", 32'(out_len), 9);
    do_reset();
    ld1_delay = 0;

    // Address wrap at the top of the address space
    send_cmd(16'hFFFE, 16'hFFF8, 4'd1);
    wait_done(200);
    check_stream("t5", 16'hFFFE, 16'hFFF8, 1);
    check_val("t5_first_waddr", (addr_q.size() > 4) ? 32'(addr_q[4]) : 32'hFFFF_FFFF, 32'h0000_FFF8);
    check_val("t5_wrapped_waddr", (addr_q.size() > 12) ? 32'(addr_q[12]) : 32'hFFFF_FFFF, 32'h0000_0000);
    do_reset();

    // Reset in the middle of the weight load
    send_cmd(16'h0010, 16'h0100, 4'd1);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("t6_async_reset_outputs",
              32'({mem_ren, mem_addr, npu_x_load_val, npu_w_load_val,
                   npu_w_load_sel, npu_mac_val, npu_out_val, done, busy}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_val("t6_no_done_after_reset", 32'(done_cnt), 0);
    check_val("t6_cmd_rdy_after_reset", 32'(cmd_if.cmd_rdy), 1);
    send_cmd(16'h0030, 16'h0300, 4'd1);
    wait_done(200);
    check_stream("t6", 16'h0030, 16'h0300, 1);
    check_val("t6_done_cycle", 32'(done_rel), 31);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
